// File: rtl/sprite_palette_lut.sv
// Sprite palette lookup: NUM_PAL palettes of 2**INDEX_W 12-bit RGB entries.
// After reset the palettes self-initialise (index 0 = colour key magenta,
// everything else black). Afterwards the block serves one pixel lookup per
// cycle with a fixed two-cycle latency. It also provides a frame-based
// flash-to-white effect.
//
// Handshake: in_valid is a one-cycle request with no ready. A request accepted
// at edge N produces out_valid=1 with data after edge N+2. There is no
// backpressure, and requests presented while busy=1 are dropped.
module sprite_palette_lut #(
    parameter int INDEX_W      = 4,
    parameter int NUM_PAL      = 4,
    parameter int FLASH_FRAMES = 8,
    localparam int PAL_W       = $clog2(NUM_PAL)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               in_valid,
    input  logic [PAL_W-1:0]   pal_sel,
    input  logic [INDEX_W-1:0] index,
    input  logic               flash_en,
    input  logic               frame_tick,
    input  logic               wr_en,
    input  logic [PAL_W-1:0]   wr_pal,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [11:0]        wr_rgb,
    output logic               busy,
    output logic               out_valid,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               transparent
);

    localparam int ADDR_W = PAL_W + INDEX_W;
    localparam int DEPTH  = NUM_PAL * (2 ** INDEX_W);
    localparam int FC_W   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [FC_W-1:0]   LAST_FRAME = FC_W'(FLASH_FRAMES - 1);
    localparam logic [11:0]       KEY_RGB   = 12'hF0B;

    typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   init_addr;

    logic [11:0]         mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [11:0]         mem_wdata;

    logic                s1_valid;
    logic                s1_key;
    logic                s1_flash;
    logic [11:0]         s1_data;
    logic                s2_valid;
    logic                s2_key;
    logic                s2_flash;
    logic [11:0]         s2_data;

    logic [FC_W-1:0]     frame_cnt;
    logic                phase;

    // FSM state register; reset always restarts initialisation.
    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_INIT;
        else       state <= next_state;
    end

    // Next state: leave INIT once the final entry is being written.
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT: if (init_addr == LAST_ADDR) next_state = ST_RUN;
            ST_RUN:  next_state = ST_RUN;
            default: next_state = ST_INIT;
        endcase
    end

    assign busy = (state == ST_INIT);

    // Init address walks every entry in {pal,index} order, one per cycle.
    always_ff @(posedge Clk) begin
        if (Reset)               init_addr <= '0;
        else if (state == ST_INIT) init_addr <= init_addr + ADDR_W'(1);
    end

    // Write port select: initialisation owns the port while busy, user writes are ignored.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_addr;
            mem_wdata = (init_addr[INDEX_W-1:0] == '0) ? KEY_RGB : 12'h000;
        end else if (wr_en) begin
            mem_we    = 1'b1;
            mem_waddr = {wr_pal, wr_index};
            mem_wdata = wr_rgb;
        end
    end

    // Palette RAM write port.
    always_ff @(posedge Clk) begin
        if (!Reset && mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Palette RAM read port; a same-edge write is not visible here (old data).
    always_ff @(posedge Clk) begin
        s1_data <= mem[{pal_sel, index}];
    end

    // Pipeline control bits; lookups are only accepted in RUN.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_key   <= 1'b0;
            s1_flash <= 1'b0;
            s2_valid <= 1'b0;
            s2_key   <= 1'b0;
            s2_flash <= 1'b0;
        end else begin
            s1_valid <= in_valid && (state == ST_RUN);
            s1_key   <= (index == '0);
            s1_flash <= flash_en;
            s2_valid <= s1_valid;
            s2_key   <= s1_key;
            s2_flash <= s1_flash;
        end
    end

    // Second data stage: plain delay to reach the two-cycle latency.
    always_ff @(posedge Clk) begin
        s2_data <= s1_data;
    end

    // Frame counter and flash phase; phase toggles when the counter wraps.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt == LAST_FRAME) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end

    // Output stage: apply flash using the current phase, hold values when idle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid   <= 1'b0;
            red         <= 4'h0;
            green       <= 4'h0;
            blue        <= 4'h0;
            transparent <= 1'b0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                transparent <= s2_key;
                if (s2_flash && phase && !s2_key) begin
                    red   <= 4'hF;
                    green <= 4'hF;
                    blue  <= 4'hF;
                end else begin
                    red   <= s2_data[11:8];
                    green <= s2_data[7:4];
                    blue  <= s2_data[3:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Directed bench for sprite_palette_lut with default parameters.
module tb_sprite_palette_lut;

    localparam int INDEX_W = 4;
    localparam int NUM_PAL = 4;
    localparam int PAL_W   = 2;

    logic               Clk;
    logic               Reset;
    logic               in_valid;
    logic [PAL_W-1:0]   pal_sel;
    logic [INDEX_W-1:0] index;
    logic               flash_en;
    logic               frame_tick;
    logic               wr_en;
    logic [PAL_W-1:0]   wr_pal;
    logic [INDEX_W-1:0] wr_index;
    logic [11:0]        wr_rgb;
    logic               busy;
    logic               out_valid;
    logic [3:0]         red;
    logic [3:0]         green;
    logic [3:0]         blue;
    logic               transparent;

    int checks = 0;
    int errors = 0;

    sprite_palette_lut #(.INDEX_W(INDEX_W), .NUM_PAL(NUM_PAL), .FLASH_FRAMES(8)) dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .pal_sel(pal_sel),
        .index(index), .flash_en(flash_en), .frame_tick(frame_tick),
        .wr_en(wr_en), .wr_pal(wr_pal), .wr_index(wr_index), .wr_rgb(wr_rgb),
        .busy(busy), .out_valid(out_valid), .red(red), .green(green),
        .blue(blue), .transparent(transparent)
    );

    // Clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge, then settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_write(input logic [PAL_W-1:0] p, input logic [INDEX_W-1:0] i,
                            input logic [11:0] rgb);
        wr_en = 1'b1; wr_pal = p; wr_index = i; wr_rgb = rgb;
        tick();
        wr_en = 1'b0;
    endtask

    // Single isolated lookup; returns what appears two edges later.
    task automatic do_lookup(input logic [PAL_W-1:0] p, input logic [INDEX_W-1:0] i,
                             input logic fl, output logic [11:0] rgb,
                             output logic tr, output logic ov);
        in_valid = 1'b1; pal_sel = p; index = i; flash_en = fl;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rgb = {red, green, blue};
        tr  = transparent;
        ov  = out_valid;
    endtask

    // Wait (bounded) for initialisation to finish; reports edges taken and any out_valid seen.
    task automatic wait_init(output int cycles, output logic seen_valid);
        cycles = 0;
        seen_valid = 1'b0;
        while (busy && cycles < 200) begin
            tick();
            cycles++;
            if (out_valid) seen_valid = 1'b1;
        end
    endtask

    task automatic test_reset();
        int cyc;
        logic seen;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if ({red, green, blue, transparent} !== 13'h0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", {red, green, blue, transparent});
        end
        wait_init(cyc, seen);
        checks++;
        if (cyc !== 64) begin errors++; $display("FAIL init_length got %0d want 64", cyc); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_init got %b want 0", busy); end
    endtask

    task automatic test_defaults();
        logic [11:0] rgb;
        logic tr, ov;
        in_valid = 1'b1; pal_sel = 2'd2; index = 4'd0; flash_en = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got %b want 0", out_valid); end
        tick();
        checks++;
        if ({out_valid, red, green, blue, transparent} !== {1'b1, 12'hF0B, 1'b1}) begin
            errors++; $display("FAIL default_key got v=%b rgb=%h t=%b want v=1 rgb=f0b t=1",
                               out_valid, {red, green, blue}, transparent);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || {red, green, blue} !== 12'hF0B) begin
            errors++; $display("FAIL hold_idle got v=%b rgb=%h want v=0 rgb=f0b", out_valid, {red, green, blue});
        end
        do_lookup(2'd2, 4'd5, 1'b0, rgb, tr, ov);
        checks++;
        if ({ov, rgb, tr} !== {1'b1, 12'h000, 1'b0}) begin
            errors++; $display("FAIL default_black got v=%b rgb=%h t=%b want v=1 rgb=000 t=0", ov, rgb, tr);
        end
    endtask

    task automatic test_write_read();
        // Edge N: write + lookup same entry; N+1: lookup again; N+2: other palette.
        wr_en = 1'b1; wr_pal = 2'd1; wr_index = 4'd3; wr_rgb = 12'h941;
        in_valid = 1'b1; pal_sel = 2'd1; index = 4'd3; flash_en = 1'b0;
        tick();
        wr_en = 1'b0;
        tick();
        pal_sel = 2'd0;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, red, green, blue} !== {1'b1, 12'h000}) begin
            errors++; $display("FAIL same_cycle_old got v=%b rgb=%h want v=1 rgb=000", out_valid, {red, green, blue});
        end
        tick();
        checks++;
        if ({out_valid, red, green, blue} !== {1'b1, 12'h941}) begin
            errors++; $display("FAIL next_cycle_new got v=%b rgb=%h want v=1 rgb=941", out_valid, {red, green, blue});
        end
        tick();
        checks++;
        if ({out_valid, red, green, blue, transparent} !== {1'b1, 12'h000, 1'b0}) begin
            errors++; $display("FAIL other_palette got v=%b rgb=%h t=%b want v=1 rgb=000 t=0",
                               out_valid, {red, green, blue}, transparent);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_rgb [16];
        logic [3:0] k;
        for (int i = 0; i < 16; i++) begin
            k = 4'(i);
            exp_rgb[i] = {k, 4'hF - k, k ^ 4'h5};
            do_write(2'd1, k, exp_rgb[i]);
        end
        flash_en = 1'b0;
        pal_sel = 2'd1;
        for (int c = 0; c < 18; c++) begin
            if (c < 16) begin in_valid = 1'b1; index = 4'(c); end
            else in_valid = 1'b0;
            tick();
            if (c == 1) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_start got v=%b want 0", out_valid); end
            end
            if (c >= 2) begin
                checks++;
                if ({out_valid, red, green, blue, transparent} !== {1'b1, exp_rgb[c-2], (c == 2)}) begin
                    errors++; $display("FAIL stream_%0d got v=%b rgb=%h t=%b want v=1 rgb=%h t=%b",
                                       c - 2, out_valid, {red, green, blue}, transparent, exp_rgb[c-2], (c == 2));
                end
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got v=%b want 0", out_valid); end
    endtask

    task automatic test_flash();
        logic [11:0] rgb;
        logic tr, ov;
        do_write(2'd2, 4'd9, 12'hF00);
        do_lookup(2'd2, 4'd9, 1'b1, rgb, tr, ov);
        checks++;
        if ({ov, rgb} !== {1'b1, 12'hF00}) begin errors++; $display("FAIL flash_phase0 got v=%b rgb=%h want f00", ov, rgb); end
        frame_tick = 1'b1;
        repeat (8) tick();
        frame_tick = 1'b0;
        do_lookup(2'd2, 4'd9, 1'b1, rgb, tr, ov);
        checks++;
        if ({ov, rgb, tr} !== {1'b1, 12'hFFF, 1'b0}) begin errors++; $display("FAIL flash_white got v=%b rgb=%h t=%b want fff t=0", ov, rgb, tr); end
        do_lookup(2'd2, 4'd9, 1'b0, rgb, tr, ov);
        checks++;
        if ({ov, rgb} !== {1'b1, 12'hF00}) begin errors++; $display("FAIL flash_disabled got v=%b rgb=%h want f00", ov, rgb); end
        do_lookup(2'd2, 4'd0, 1'b1, rgb, tr, ov);
        checks++;
        if ({ov, rgb, tr} !== {1'b1, 12'hF0B, 1'b1}) begin errors++; $display("FAIL flash_key got v=%b rgb=%h t=%b want f0b t=1", ov, rgb, tr); end
        // Seven more ticks; the eighth lands on the output edge of lookup A.
        frame_tick = 1'b1;
        repeat (7) tick();
        frame_tick = 1'b0;
        in_valid = 1'b1; pal_sel = 2'd2; index = 4'd9; flash_en = 1'b1;
        tick();
        tick();
        in_valid = 1'b0; frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        checks++;
        if ({out_valid, red, green, blue} !== {1'b1, 12'hFFF}) begin
            errors++; $display("FAIL phase_edge_old got v=%b rgb=%h want fff", out_valid, {red, green, blue});
        end
        tick();
        checks++;
        if ({out_valid, red, green, blue} !== {1'b1, 12'hF00}) begin
            errors++; $display("FAIL phase_edge_new got v=%b rgb=%h want f00", out_valid, {red, green, blue});
        end
        flash_en = 1'b0;
        tick();
    endtask

    task automatic test_init_lockout();
        int n;
        logic seen;
        logic [11:0] rgb;
        logic tr, ov;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        wr_en = 1'b1; wr_pal = 2'd0; wr_index = 4'd1; wr_rgb = 12'hABC;
        in_valid = 1'b1; pal_sel = 2'd0; index = 4'd1; flash_en = 1'b0;
        n = 0; seen = 1'b0;
        while (busy && n < 200) begin
            tick();
            n++;
            if (out_valid) seen = 1'b1;
        end
        wr_en = 1'b0; in_valid = 1'b0;
        repeat (2) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (n !== 64) begin errors++; $display("FAIL lockout_init_length got %0d want 64", n); end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL lockout_out_valid got %b want 0", seen); end
        do_lookup(2'd0, 4'd1, 1'b0, rgb, tr, ov);
        checks++;
        if ({ov, rgb} !== {1'b1, 12'h000}) begin errors++; $display("FAIL lockout_entry got v=%b rgb=%h want 000", ov, rgb); end
        do_lookup(2'd1, 4'd3, 1'b0, rgb, tr, ov);
        checks++;
        if ({ov, rgb} !== {1'b1, 12'h000}) begin errors++; $display("FAIL reinit_user_entry got v=%b rgb=%h want 000", ov, rgb); end
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        logic seen;
        logic [11:0] rgb;
        logic tr, ov;
        do_write(2'd3, 4'd7, 12'h0FF);
        do_lookup(2'd3, 4'd7, 1'b0, rgb, tr, ov);
        checks++;
        if ({ov, rgb} !== {1'b1, 12'h0FF}) begin errors++; $display("FAIL midop_write got v=%b rgb=%h want 0ff", ov, rgb); end
        in_valid = 1'b1; pal_sel = 2'd3; index = 4'd7; flash_en = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, busy} !== 2'b01) begin
            errors++; $display("FAIL midop_flush got v=%b busy=%b want v=0 busy=1", out_valid, busy);
        end
        wait_init(cyc, seen);
        checks++;
        if (seen !== 1'b0 || cyc !== 64) begin
            errors++; $display("FAIL midop_reinit got seen=%b cycles=%0d want seen=0 cycles=64", seen, cyc);
        end
        do_lookup(2'd3, 4'd7, 1'b0, rgb, tr, ov);
        checks++;
        if ({ov, rgb} !== {1'b1, 12'h000}) begin errors++; $display("FAIL midop_entry got v=%b rgb=%h want 000", ov, rgb); end
    endtask

    // Test sequence and final report.
    initial begin
        Reset = 1'b1; in_valid = 1'b0; pal_sel = '0; index = '0; flash_en = 1'b0;
        frame_tick = 1'b0; wr_en = 1'b0; wr_pal = '0; wr_index = '0; wr_rgb = '0;
        tick();
        test_reset();
        test_defaults();
        test_write_read();
        test_back_to_back();
        test_flash();
        test_init_lockout();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_palette_lut.md
SPRITE_PALETTE_LUT -- requirements
Module: sprite_palette_lut

Interface
REQ-001 SHALL provide parameter INDEX_W, default 4, pixel colour-index width (2**INDEX_W entries per palette).
REQ-002 SHALL provide parameter NUM_PAL, default 4, number of independent palettes (power of two, >=2).
REQ-003 SHALL provide parameter FLASH_FRAMES, default 8, frames per flash half-period.
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports are named Clk and Reset.
REQ-005 Ports (name  direction  width  meaning):
 Clk  in  1  system clock
 Reset  in  1  synchronous active-high reset
 in_valid  in  1  pixel lookup request this cycle
 pal_sel  in  clog2(NUM_PAL)  palette for this lookup
 index  in  INDEX_W  colour index for this lookup
 flash_en  in  1  flash-to-white enable for this lookup
 frame_tick  in  1  one-cycle pulse per video frame
 wr_en  in  1  palette entry write request
 wr_pal  in  clog2(NUM_PAL)  palette written
 wr_index  in  INDEX_W  entry written
 wr_rgb  in  12  {R,G,B} 4 bits each
 busy  out  1  initialisation in progress
 out_valid  out  1  red/green/blue/transparent valid
 red, green, blue  out  4 each  looked-up colour
 transparent  out  1  pixel is colour key

Function
REQ-006 SHALL store NUM_PAL x 2**INDEX_W entries of 12 bits in internal RAM (one read port, one write port).
REQ-007 SHALL implement FSM states INIT and RUN; Reset forces INIT with init address 0.
REQ-008 In INIT SHALL write one entry per cycle in ascending order {pal,index}: index 0 = 12'hF0B (key magenta), all others = 12'h000; busy=1.
REQ-009 SHALL transition INIT->RUN the cycle after writing the last entry (NUM_PAL*2**INDEX_W cycles after Reset deasserts); busy=0 from that cycle.
REQ-010 During INIT SHALL ignore wr_en and in_valid; out_valid stays 0.
REQ-011 In RUN SHALL write wr_rgb to entry {wr_pal,wr_index} on the rising edge where wr_en=1.
REQ-012 Lookup latency SHALL be exactly 2 cycles: in_valid at edge N -> out_valid=1 with data after edge N+2; fully pipelined, one lookup per cycle, no backpressure.
REQ-013 Simultaneous write and lookup of the same entry SHALL return the pre-write (old) value; lookups issued one or more cycles later SHALL return the new value.
REQ-014 transparent SHALL be 1 iff looked-up index==0, independent of stored colour; RGB still output.
REQ-015 SHALL keep a frame counter 0..FLASH_FRAMES-1 and flash phase bit; on frame_tick counter increments; at wrap to 0 phase toggles.
REQ-016 If flash_en (pipelined with the lookup) and phase=1 and transparent=0, output SHALL be 4'hF on red, green, blue; otherwise stored colour.
REQ-017 Phase sampled in pipeline stage 2; a frame_tick toggling phase in the same cycle affects only outputs produced after that edge.
REQ-018 When out_valid=0, red/green/blue/transparent SHALL hold their previous values.
REQ-019 pal_sel/wr_pal values >= NUM_PAL cannot occur (power-of-two NUM_PAL); no range check required.

Reset
REQ-020 On Reset SHALL set: state INIT, busy=1, out_valid=0, red=green=blue=0, transparent=0, frame counter=0, phase=0, pipeline valid bits=0.
REQ-021 Reset asserted mid-INIT or mid-RUN SHALL restart initialisation from address 0, discard in-flight lookups, and overwrite all user-written entries.

Verification
REQ-022 Defaults: Reset 1 cycle, wait 64 cycles (default params) -> busy falls on cycle 64; lookup pal 2 idx 0 -> F0B, transparent=1; idx 5 -> 000, transparent=0, 2 cycles latency.
REQ-023 Write/read: write pal1 idx3 = 12'h941, lookup same entry same cycle -> 000; next cycle lookup -> 941; pal0 idx3 still 000.
REQ-024 Streaming: 16 back-to-back lookups idx 0..15 pal 1 -> 16 consecutive out_valid cycles, data in order, no gaps.
REQ-025 Flash: entry F00, flash_en=1, 8 frame_ticks -> output FFF; 8 more -> F00; index 0 with flash -> F0B, transparent=1.
REQ-026 Init lockout: wr_en and in_valid asserted during INIT -> no out_valid, entries equal defaults after INIT.
REQ-027 Reset mid-operation: write pal3 idx7=0FF, Reset during in-flight lookups -> out_valid 0 next cycle, busy=1, after INIT entry reads 000.
